// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bundle between the ID/EX register, the RV32M unit and the EX/MEM register.
interface ex_muldiv_unit_if;
    logic        start_i;
    logic [9:0]  func73_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [4:0]  rd_i;
    logic        kill_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        RegWrite_o;

    modport slave (
        input  start_i, func73_i, data1_i, data2_i, rd_i, kill_i,
        output busy_o, stall_o, done_o, result_o, rd_o, RegWrite_o
    );

    modport master (
        output start_i, func73_i, data1_i, data2_i, rd_i, kill_i,
        input  busy_o, stall_o, done_o, result_o, rd_o, RegWrite_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide) for the EX stage.
// Optional macro MULDIV_EARLY_OUT_EN: trivial cases (x/0, signed overflow, multiply by 0) skip RUN.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ex_muldiv_unit_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t            state_r, state_nxt;
    logic [4:0]        cnt_r;
    logic [2:0]        op_r;
    logic [4:0]        rd_r, rd_out_r;
    logic              a_neg_r, b_neg_r;
    logic [XLEN-1:0]   hi_r, lo_r, b_r, result_r;

    logic [2:0]        f3_s;
    logic              qual_s, signed1_s, signed2_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              early_s;
    logic [XLEN-1:0]   early_res_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [XLEN-1:0]   hi_nxt_s, lo_nxt_s, quo_s, rem_s, final_res_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;

    assign f3_s      = bus.func73_i[2:0];
    assign qual_s    = bus.start_i && (bus.func73_i[9:3] == 7'b0000001);
    assign signed1_s = (f3_s == 3'b001) || (f3_s == 3'b010) || (f3_s == 3'b100) || (f3_s == 3'b110);
    assign signed2_s = (f3_s == 3'b001) || (f3_s == 3'b100) || (f3_s == 3'b110);
    assign a_neg_s   = signed1_s && bus.data1_i[XLEN-1];
    assign b_neg_s   = signed2_s && bus.data2_i[XLEN-1];
    assign a_mag_s   = a_neg_s ? -bus.data1_i : bus.data1_i;
    assign b_mag_s   = b_neg_s ? -bus.data2_i : bus.data2_i;

    // Trivial operations that can bypass the iterative core
    always_comb begin
        early_s     = 1'b0;
        early_res_s = {XLEN{1'b0}};
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3_s[2]) begin
            early_s = (bus.data1_i == 32'd0) || (bus.data2_i == 32'd0);
        end else if (bus.data2_i == 32'd0) begin
            early_s     = 1'b1;
            early_res_s = f3_s[1] ? bus.data1_i : 32'hFFFF_FFFF;
        end else if (!f3_s[0] && (bus.data1_i == 32'h8000_0000) && (bus.data2_i == 32'hFFFF_FFFF)) begin
            early_s     = 1'b1;
            early_res_s = f3_s[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            early_s = 1'b0;
        end
`endif
    end

    // One multiply or divide step over the {hi, lo} pair
    assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
    assign div_shift_s = {hi_r, lo_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, b_r};

    always_comb begin
        if (!op_r[2]) begin
            hi_nxt_s = mul_sum_s[XLEN:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end else if (!div_diff_s[XLEN]) begin
            hi_nxt_s = div_diff_s[XLEN-1:0];
            lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
        end else begin
            hi_nxt_s = div_shift_s[XLEN-1:0];
            lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction applied to the last step's magnitudes
    assign prod_s     = {hi_nxt_s, lo_nxt_s};
    assign prod_fix_s = (a_neg_r ^ b_neg_r) ? -prod_s : prod_s;
    assign quo_s      = (b_r == 32'd0) ? 32'hFFFF_FFFF : ((a_neg_r ^ b_neg_r) ? -lo_nxt_s : lo_nxt_s);
    assign rem_s      = a_neg_r ? -hi_nxt_s : hi_nxt_s;

    always_comb begin
        case (op_r)
            3'b000:                 final_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res_s = quo_s;
            3'b110, 3'b111:         final_res_s = rem_s;
            default:                final_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; kill wins over everything including a same-cycle start
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (qual_s && !bus.kill_i) begin
                    state_nxt = early_s ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (bus.kill_i) begin
                    state_nxt = IDLE;
                end else if (cnt_r == 5'(ITER - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_r <= IDLE;
        else       state_r <= state_nxt;
    end

    // Operand capture, iteration and result/tag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r    <= 5'd0;
            op_r     <= 3'd0;
            rd_r     <= 5'd0;
            rd_out_r <= 5'd0;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (qual_s && !bus.kill_i) begin
                        cnt_r   <= 5'd0;
                        op_r    <= f3_s;
                        rd_r    <= bus.rd_i;
                        a_neg_r <= a_neg_s;
                        b_neg_r <= b_neg_s;
                        hi_r    <= {XLEN{1'b0}};
                        lo_r    <= a_mag_s;
                        b_r     <= b_mag_s;
                        if (early_s) begin
                            result_r <= early_res_s;
                            rd_out_r <= bus.rd_i;
                        end
                    end
                end
                RUN: begin
                    if (!bus.kill_i) begin
                        hi_r  <= hi_nxt_s;
                        lo_r  <= lo_nxt_s;
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == 5'(ITER - 1)) begin
                            result_r <= final_res_s;
                            rd_out_r <= rd_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o     = (state_r == RUN);
    assign bus.stall_o    = (state_r == RUN) || ((state_r == IDLE) && qual_s);
    assign bus.done_o     = (state_r == DONE) && !bus.kill_i;
    assign bus.result_o   = result_r;
    assign bus.rd_o       = rd_out_r;
    assign bus.RegWrite_o = bus.done_o && (rd_out_r != 5'd0);
endmodule
